uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Configurable data width,
//  parity and stop bits, 2-FF input synchroniser, held valid with ack handshake, parity/framing/
//  overrun/break flags. Sits between the rx pad and the command/FIFO logic; one instance per UART.
// PARAMETERS
//  SYS_CLK_FREQ  12000000  system clock in Hz
//  BAUD_RATE     115200    line rate; CLKS_PER_BIT = SYS_CLK_FREQ/BAUD_RATE (integer, must be >=4)
//  DATA_BITS     8         data bits per frame, 5..9, LSB first
//  PARITY        0         0 none, 1 odd, 2 even
//  STOP_BITS     1         1 or 2
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  reset         in   1          asynchronous, active-low reset
//  rx            in   1          serial line, idle high, asynchronous to clk
//  data_ack      in   1          consumer accepts data_out while ready=1
//  data_out      out  DATA_BITS  last received word
//  ready         out  1          word valid; held until data_ack
//  parity_error  out  1          parity mismatch for word in data_out (0 when PARITY=0)
//  frame_error   out  1          a stop bit sampled 0 for word in data_out
//  overrun       out  1          a word completed while ready=1 and no ack; previous word lost
//  break_detect  out  1          all data, parity and stop samples 0
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0, FSM IDLE, counters 0, synchroniser stages 1.
//  rx passes through 2 FFs -> rx_s; all decisions use rx_s (2-clk input latency).
//  FSM IDLE: rx_s==0 -> START, bit counter cleared.
//  START: at clk count CLKS_PER_BIT/2-1 sample rx_s; 1 -> IDLE (glitch, no flags); 0 -> DATA.
//  DATA: sample every CLKS_PER_BIT clks, shift in LSB first; after DATA_BITS samples -> PARITY
//    if PARITY!=0 else STOP.
//  PARITY: one sample; odd: XOR(data,p)==1 required, even: ==0; mismatch -> parity_error.
//  STOP: STOP_BITS samples; any 0 -> frame_error. After final stop sample -> DONE.
//  DONE (1 clk): latch data_out and all flags, ready<=1; -> IDLE if frame good, else WAIT_HIGH.
//  WAIT_HIGH: stay until rx_s==1, then IDLE (line held low never re-triggers a frame).
//  break_detect=1 implies frame_error=1; parity_error still computed normally.
//  Handshake: ready falls the clk after data_ack&ready; flags clear together with ready.
//    data_ack with ready=0 ignored. Flags valid only while ready=1.
//  Overrun: DONE while ready=1 and no ack in same clk -> data_out/flags overwritten, overrun=1.
//  DONE and data_ack in same clk: new word wins, ready stays 1, overrun=0.
//  Counters sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1); bit counter wraps only via
//    state change, never free-running.
//  Reset mid-frame: partial word discarded, no flags, IDLE after release.
//  Latency: ready rises 1 clk after final stop sample (+2 clk synchroniser from rx edge).
// TESTING (SYS_CLK_FREQ=4, BAUD_RATE=1 -> 4 clk/bit, unless noted)
//  1 8N1: send 0xAA, stop=1 -> ready=1, data_out=0xAA, all flags 0; ack -> ready=0 next clk.
//  2 DATA_BITS=7,PARITY=2,STOP_BITS=2: send 0x55 parity 0 -> ok; resend parity 1 ->
//    parity_error=1, data_out=0x55, frame_error=0.
//  3 Glitch: rx low 1 clk then high -> FSM returns IDLE, ready stays 0.
//  4 Overrun: two 0x3C/0xC3 frames, no ack -> data_out=0xC3, overrun=1; ack clears both.
//  5 Break: rx low 20 bit periods -> ready=1, data_out=0, frame_error=1, break_detect=1;
//    no second frame until rx high then low again.
//  6 Reset: assert reset during bit 4 -> outputs 0 immediately; next 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF synchroniser, configurable data/parity/stop framing,
// held output word with ack handshake and parity/framing/overrun/break status.
module uart_rx_cfg #(
    parameter int unsigned SYS_CLK_FREQ = 12000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 break_detect
);

    localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HalfCnt  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FullCnt  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LastData = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LastStop = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StDone, StWaitHigh
    } state_e;

    state_e state_q, state_d;
    logic rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic par_err_q, par_err_d, frm_err_q, frm_err_d, zero_q, zero_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic ready_q, ready_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, brk_q, brk_d;
    logic sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            zero_q    <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            zero_q    <= zero_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            brk_q     <= brk_d;
        end
    end

    assign sample = (cnt_q == FullCnt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        zero_d    = zero_q;
        data_d    = data_q;
        ready_d   = ready_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ov_d      = ov_q;
        brk_d     = brk_q;

        // Consumer ack retires the word; a word completing in this same clk overrides below.
        if (ready_q && data_ack) begin
            ready_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            ov_d    = 1'b0;
            brk_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        zero_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (sample) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~rx_s_q;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (sample) begin
                    cnt_d     = '0;
                    zero_d    = zero_q & ~rx_s_q;
                    par_err_d = (PARITY == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (sample) begin
                    cnt_d  = '0;
                    zero_d = zero_q & ~rx_s_q;
                    if (!rx_s_q) frm_err_d = 1'b1;
                    if (bit_q == LastStop) state_d = StDone;
                    else bit_d = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                data_d  = shift_q;
                ready_d = 1'b1;
                pe_d    = par_err_q;
                fe_d    = frm_err_q;
                brk_d   = zero_q;
                ov_d    = ready_q & ~data_ack;
                // A low stop bit means the line may still be low; wait for idle before rearming.
                state_d = frm_err_q ? StWaitHigh : StIdle;
            end
            StWaitHigh: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out     = data_q;
    assign ready        = ready_q;
    assign parity_error = pe_q;
    assign frame_error  = fe_q;
    assign overrun      = ov_q;
    assign break_detect = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance, scoreboard of expected words popped by a
// monitor whenever a new word is presented on ready.
module tb_uart_rx_cfg;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, ack_a = 1'b0, ack_b = 1'b0;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic rdy_a, pe_a, fe_a, ov_a, brk_a;
    logic rdy_b, pe_b, fe_b, ov_b, brk_b;

    uart_rx_cfg #(
        .SYS_CLK_FREQ(4), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(rst_n), .rx(rx_a), .data_ack(ack_a), .data_out(dout_a),
        .ready(rdy_a), .parity_error(pe_a), .frame_error(fe_a), .overrun(ov_a),
        .break_detect(brk_a)
    );

    uart_rx_cfg #(
        .SYS_CLK_FREQ(4), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(rst_n), .rx(rx_b), .data_ack(ack_b), .data_out(dout_b),
        .ready(rdy_b), .parity_error(pe_b), .frame_error(fe_b), .overrun(ov_b),
        .break_detect(brk_b)
    );

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
        logic       brk;
    } word_t;

    word_t qa[$];
    word_t qb[$];
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t snap(input int ch);
        word_t w;
        if (ch == 0) w = '{data: {1'b0, dout_a}, pe: pe_a, fe: fe_a, ov: ov_a, brk: brk_a};
        else w = '{data: {2'b0, dout_b}, pe: pe_b, fe: fe_b, ov: ov_b, brk: brk_b};
        return w;
    endfunction

    // Reference: what a frame means, from its line content.
    function automatic word_t model_a(input logic [7:0] d, input logic stop, input logic ov);
        return '{data: {1'b0, d}, pe: 1'b0, fe: ~stop, ov: ov, brk: (d == 8'h00) && !stop};
    endfunction

    function automatic word_t model_b(input logic [6:0] d, input logic p, input logic [1:0] st);
        return '{data: {2'b0, d}, pe: ^{d, p}, fe: (st != 2'b11), ov: 1'b0,
                 brk: (d == 7'h00) && !p && (st == 2'b00)};
    endfunction

    word_t prev[2];
    logic  prev_rdy[2];

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            word_t cur;
            word_t e;
            logic  r;
            cur = snap(ch);
            r = (ch == 0) ? rdy_a : rdy_b;
            if (!rst_n) begin
                prev_rdy[ch] = 1'b0;
                prev[ch] = '0;
            end else begin
                if (r && (!prev_rdy[ch] || cur != prev[ch])) begin
                    if ((ch == 0 && qa.size() == 0) || (ch == 1 && qb.size() == 0)) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word ch%0d: got 0x%0h expected none", ch, cur);
                    end else begin
                        if (ch == 0) e = qa.pop_front();
                        else e = qb.pop_front();
                        check(ch == 0 ? "word_a {data,pe,fe,ov,brk}" : "word_b {data,pe,fe,ov,brk}",
                              32'(cur), 32'(e));
                    end
                end
                prev_rdy[ch] = r;
                prev[ch] = cur;
            end
        end
    end

    task automatic set_rx(input int ch, input logic v);
        if (ch == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_bit(input int ch, input logic v);
        set_rx(ch, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [8:0] d, input int nbits, input bit has_par,
                              input logic p, input logic [1:0] stops, input int nstop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(ch, d[i]);
        if (has_par) send_bit(ch, p);
        for (int i = 0; i < nstop; i++) send_bit(ch, stops[i]);
        send_bit(ch, 1'b1);
        send_bit(ch, 1'b1);
    endtask

    task automatic wait_ready(input int ch);
        int n = 0;
        while (!((ch == 0) ? rdy_a : rdy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout ch%0d: got ready=0 expected ready=1", ch);
        end
    endtask

    task automatic do_ack(input int ch);
        wait_ready(ch);
        if (ch == 0) ack_a = 1'b1;
        else ack_b = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        if (ch == 0) begin
            check("ack_clears_ready_a", 32'(rdy_a), 0);
            check("ack_clears_flags_a", 32'({pe_a, fe_a, ov_a, brk_a}), 0);
        end else begin
            check("ack_clears_ready_b", 32'(rdy_b), 0);
            check("ack_clears_flags_b", 32'({pe_b, fe_b, ov_b, brk_b}), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d8;
        logic [6:0] d7;
        logic       st, p;
        logic [1:0] st2;

        repeat (3) @(negedge clk);
        check("reset_outputs_a", 32'({rdy_a, dout_a, pe_a, fe_a, ov_a, brk_a}), 0);
        check("reset_outputs_b", 32'({rdy_b, dout_b, pe_b, fe_b, ov_b, brk_b}), 0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // 8N1 basic word
        qa.push_back(model_a(8'hAA, 1'b1, 1'b0));
        send_frame(0, 9'h0AA, 8, 1'b0, 1'b0, 2'b11, 1);
        do_ack(0);

        // 7E2: good parity, then bad parity
        qb.push_back(model_b(7'h55, 1'b0, 2'b11));
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 2'b11, 2);
        do_ack(1);
        qb.push_back(model_b(7'h55, 1'b1, 2'b11));
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 2'b11, 2);
        do_ack(1);

        // One-clock glitch must not start a frame
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("glitch_no_ready", 32'(rdy_a), 0);

        for (int i = 0; i < 8; i++) begin
            d8 = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            qa.push_back(model_a(d8, st, 1'b0));
            send_frame(0, {1'b0, d8}, 8, 1'b0, 1'b0, {1'b1, st}, 1);
            do_ack(0);
        end

        for (int i = 0; i < 8; i++) begin
            d7 = 7'($urandom);
            p = 1'($urandom);
            st2 = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            qb.push_back(model_b(d7, p, st2));
            send_frame(1, {2'b0, d7}, 7, 1'b1, p, st2, 2);
            do_ack(1);
        end

        // Overrun: two words with no ack in between
        qa.push_back(model_a(8'h3C, 1'b1, 1'b0));
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1);
        qa.push_back(model_a(8'hC3, 1'b1, 1'b1));
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1);
        do_ack(0);

        // Break: line held low for 20 bit periods
        qa.push_back(model_a(8'h00, 1'b0, 1'b0));
        rx_a = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        do_ack(0);
        repeat (5 * CPB) @(negedge clk);
        check("break_no_retrigger", 32'(rdy_a), 0);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);

        // Reset mid-frame while a previous word is still held
        qa.push_back(model_a(8'h5A, 1'b1, 1'b0));
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
        d8 = 8'h81;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, d8[i]);
        rx_a = d8[4];
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_midframe_ready", 32'(rdy_a), 0);
        check("reset_midframe_data", 32'(dout_a), 0);
        check("reset_midframe_flags", 32'({pe_a, fe_a, ov_a, brk_a}), 0);
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        qa.push_back(model_a(8'h81, 1'b1, 1'b0));
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 2'b11, 1);
        do_ack(0);

        repeat (10) @(negedge clk);
        check("scoreboard_a_drained", 32'(qa.size()), 0);
        check("scoreboard_b_drained", 32'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
